// File: rtl/toa_pkg.sv
// Shared constants for the time-of-arrival counter: mode encodings and capture FSM states.
package toa_pkg;

    localparam int unsigned MODE_W  = 2;
    localparam int unsigned STATE_W = 2;

    localparam logic [MODE_W-1:0] MODE_CLEAR = 2'b00;
    localparam logic [MODE_W-1:0] MODE_HOLD  = 2'b01;
    localparam logic [MODE_W-1:0] MODE_LOAD  = 2'b10;
    localparam logic [MODE_W-1:0] MODE_COUNT = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 2'b00,
        ST_ARMED    = 2'b01,
        ST_COMPLETE = 2'b10,
        ST_TIMEOUT  = 2'b11
    } state_t;

endpackage

// File: rtl/toa_capture_channel.sv
// One hydrophone channel: rising-edge detect plus first-edge timestamp latch.
module toa_capture_channel
    import toa_pkg::*;
#(
    parameter int unsigned WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             trig_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] count_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_next_c_o
);

    logic             trig_q;
    logic             rise_c;
    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Only the first edge inside a capture window is kept; a level high at arm time is not an edge.
    always_comb begin
        rise_c  = trig_i & ~trig_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (enable_i && rise_c && !valid_q) begin
            valid_d = 1'b1;
            data_d  = count_i;
        end
    end

    // Edge-detect history runs every cycle regardless of capture state.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            trig_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            trig_q  <= trig_i;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o        = valid_q;
    assign data_o         = data_q;
    assign valid_next_c_o = valid_d;

endmodule

// File: rtl/toa_timestamp_counter.sv
// Time-of-arrival counter with per-channel first-edge capture and arm/ack release handshake.
module toa_timestamp_counter
    import toa_pkg::*;
#(
    parameter int unsigned WIDTH    = 20,
    parameter int unsigned NUM_CH   = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset_b,
    input  logic [MODE_W-1:0]       mode,
    input  logic [WIDTH-1:0]        load_value,
    input  logic                    arm,
    input  logic                    ack,
    input  logic [NUM_CH-1:0]       trig,
    output logic [WIDTH-1:0]        count_value,
    output logic                    overflow,
    output logic                    armed,
    output logic                    complete,
    output logic                    timed_out,
    output logic [NUM_CH-1:0]       capture_valid,
    output logic [NUM_CH*WIDTH-1:0] capture_data
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0]  count_q;
    logic [WIDTH-1:0]  count_d;
    logic              overflow_q;
    logic              overflow_d;
    logic              tc_c;
    state_t            state_q;
    logic              armed_q;
    logic              complete_q;
    logic              timed_out_q;
    logic              clear_c;
    logic              enable_c;
    logic              all_valid_c;
    logic [NUM_CH-1:0] ch_valid;
    logic [NUM_CH-1:0] ch_valid_next;
    logic [WIDTH-1:0]  ch_data [NUM_CH];

    assign tc_c        = (mode == MODE_COUNT) && (count_q == CNT_MAX);
    assign clear_c     = (state_q == ST_IDLE) && arm;
    assign enable_c    = (state_q == ST_ARMED);
    assign all_valid_c = &ch_valid_next;

    // Counter next-state by mode; overflow is sticky until clear or load.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        case (mode)
            MODE_CLEAR: begin
                count_d    = '0;
                overflow_d = 1'b0;
            end
            MODE_LOAD: begin
                count_d    = load_value;
                overflow_d = 1'b0;
            end
            MODE_COUNT: begin
                if (count_q != CNT_MAX) begin
                    count_d = count_q + WIDTH'(1);
                end else begin
                    overflow_d = 1'b1;
                    count_d    = SATURATE ? CNT_MAX : '0;
                end
            end
            default: begin
                count_d    = count_q;
                overflow_d = overflow_q;
            end
        endcase
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Capture controller; completion takes priority over a same-cycle terminal count.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b0;
            complete_q  <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_q <= ST_ARMED;
                        armed_q <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (all_valid_c) begin
                        state_q    <= ST_COMPLETE;
                        armed_q    <= 1'b0;
                        complete_q <= 1'b1;
                    end else if (tc_c) begin
                        state_q     <= ST_TIMEOUT;
                        armed_q     <= 1'b0;
                        timed_out_q <= 1'b1;
                    end
                end
                ST_COMPLETE, ST_TIMEOUT: begin
                    if (ack) begin
                        state_q     <= ST_IDLE;
                        complete_q  <= 1'b0;
                        timed_out_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    armed_q     <= 1'b0;
                    complete_q  <= 1'b0;
                    timed_out_q <= 1'b0;
                end
            endcase
        end
    end

    // One capture engine per hydrophone channel.
    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        toa_capture_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk           (clk),
            .reset_b       (reset_b),
            .trig_i        (trig[n]),
            .clear_i       (clear_c),
            .enable_i      (enable_c),
            .count_i       (count_q),
            .valid_o       (ch_valid[n]),
            .data_o        (ch_data[n]),
            .valid_next_c_o(ch_valid_next[n])
        );
        assign capture_data[n*WIDTH +: WIDTH] = ch_data[n];
    end

    assign count_value   = count_q;
    assign overflow      = overflow_q;
    assign armed         = armed_q;
    assign complete      = complete_q;
    assign timed_out     = timed_out_q;
    assign capture_valid = ch_valid;

endmodule

// File: tb/tb_toa_timestamp_counter.sv
// Bench: three counter configurations driven in lockstep and compared to a behavioural model.
module tb_toa_timestamp_counter;

    logic        clk;
    logic        reset_b;
    logic [1:0]  mode;
    logic [19:0] load_value;
    logic [3:0]  load4;
    logic        arm;
    logic        ack;
    logic [3:0]  trig;

    logic [19:0] cv0;
    logic [3:0]  cv1, cv2;
    logic        ov0, ov1, ov2;
    logic        ar0, ar1, ar2;
    logic        cp0, cp1, cp2;
    logic        to0, to1, to2;
    logic [3:0]  vl0, vl1, vl2;
    logic [79:0] cd0;
    logic [15:0] cd1, cd2;

    int total = 0;
    int bad   = 0;

    // Behavioural model state, one slot per DUT (0: W20 wrap, 1: W4 wrap, 2: W4 saturate).
    int unsigned m_cnt [3];
    bit          m_ovf [3];
    int          m_st  [3];   // 0 idle, 1 armed, 2 complete, 3 timeout
    bit [3:0]    m_val [3];
    int unsigned m_dat [3][4];
    bit [3:0]    m_tq  [3];

    assign load4 = load_value[3:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    toa_timestamp_counter #(.WIDTH(20), .NUM_CH(4), .SATURATE(1'b0)) u_d0 (
        .clk(clk), .reset_b(reset_b), .mode(mode), .load_value(load_value), .arm(arm), .ack(ack),
        .trig(trig), .count_value(cv0), .overflow(ov0), .armed(ar0), .complete(cp0),
        .timed_out(to0), .capture_valid(vl0), .capture_data(cd0));

    toa_timestamp_counter #(.WIDTH(4), .NUM_CH(4), .SATURATE(1'b0)) u_d1 (
        .clk(clk), .reset_b(reset_b), .mode(mode), .load_value(load4), .arm(arm), .ack(ack),
        .trig(trig), .count_value(cv1), .overflow(ov1), .armed(ar1), .complete(cp1),
        .timed_out(to1), .capture_valid(vl1), .capture_data(cd1));

    toa_timestamp_counter #(.WIDTH(4), .NUM_CH(4), .SATURATE(1'b1)) u_d2 (
        .clk(clk), .reset_b(reset_b), .mode(mode), .load_value(load4), .arm(arm), .ack(ack),
        .trig(trig), .count_value(cv2), .overflow(ov2), .armed(ar2), .complete(cp2),
        .timed_out(to2), .capture_valid(vl2), .capture_data(cd2));

    function automatic int wid(input int k);
        return (k == 0) ? 20 : 4;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0; m_ovf[k] = 1'b0; m_st[k] = 0; m_val[k] = 4'h0; m_tq[k] = 4'h0;
            for (int n = 0; n < 4; n++) m_dat[k][n] = 0;
        end
    endtask

    // One clock of the specified behaviour, using the values present before the edge.
    task automatic model_step(input int k);
        int unsigned mx;
        bit          tc;
        bit [3:0]    rise;
        mx   = (32'd1 << wid(k)) - 32'd1;
        tc   = (mode == 2'b11) && (m_cnt[k] == mx);
        rise = trig & ~m_tq[k];
        case (m_st[k])
            0: if (arm) begin
                m_st[k] = 1; m_val[k] = 4'h0;
                for (int n = 0; n < 4; n++) m_dat[k][n] = 0;
            end
            1: begin
                for (int n = 0; n < 4; n++)
                    if (rise[n] && !m_val[k][n]) begin
                        m_dat[k][n] = m_cnt[k];
                        m_val[k][n] = 1'b1;
                    end
                if (m_val[k] == 4'hF) m_st[k] = 2;
                else if (tc)          m_st[k] = 3;
            end
            default: if (ack) m_st[k] = 0;
        endcase
        case (mode)
            2'b00: begin m_cnt[k] = 0; m_ovf[k] = 1'b0; end
            2'b10: begin m_cnt[k] = 32'(load_value) & mx; m_ovf[k] = 1'b0; end
            2'b11: begin
                if (m_cnt[k] != mx) m_cnt[k] = m_cnt[k] + 1;
                else begin
                    m_ovf[k] = 1'b1;
                    if (k != 2) m_cnt[k] = 0;
                end
            end
            default: ;
        endcase
        m_tq[k] = trig;
    endtask

    task automatic check_dut(input int k);
        logic [31:0] ocnt;
        logic        oovf, oar, ocp, oto;
        logic [3:0]  oval;
        logic [31:0] odat [4];
        case (k)
            0: begin
                ocnt = 32'(cv0); oovf = ov0; oar = ar0; ocp = cp0; oto = to0; oval = vl0;
                for (int n = 0; n < 4; n++) odat[n] = 32'(cd0[n*20 +: 20]);
            end
            1: begin
                ocnt = 32'(cv1); oovf = ov1; oar = ar1; ocp = cp1; oto = to1; oval = vl1;
                for (int n = 0; n < 4; n++) odat[n] = 32'(cd1[n*4 +: 4]);
            end
            default: begin
                ocnt = 32'(cv2); oovf = ov2; oar = ar2; ocp = cp2; oto = to2; oval = vl2;
                for (int n = 0; n < 4; n++) odat[n] = 32'(cd2[n*4 +: 4]);
            end
        endcase
        chk("count_value", k, ocnt, m_cnt[k]);
        chk("overflow", k, 32'(oovf), 32'(m_ovf[k]));
        chk("armed", k, 32'(oar), 32'(m_st[k] == 1));
        chk("complete", k, 32'(ocp), 32'(m_st[k] == 2));
        chk("timed_out", k, 32'(oto), 32'(m_st[k] == 3));
        chk("capture_valid", k, 32'(oval), 32'(m_val[k]));
        for (int n = 0; n < 4; n++) chk($sformatf("capture_data[%0d]", n), k, odat[n], m_dat[k][n]);
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) check_dut(k);
    endtask

    // Advance one clock: model steps at the edge, outputs checked on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (!reset_b) model_reset();
        else for (int k = 0; k < 3; k++) model_step(k);
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset applied between edges, released on the next falling edge.
    task automatic do_reset();
        reset_b = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset_b = 1'b1;
    endtask

    initial begin
        int unsigned e1;
        reset_b = 1'b0; mode = 2'b01; load_value = '0; arm = 1'b0; ack = 1'b0; trig = 4'h0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        reset_b = 1'b1;

        // Load then count five cycles.
        mode = 2'b10; load_value = 20'h00100; cycle();
        mode = 2'b11;
        for (int i = 0; i < 5; i++) cycle();
        chk("load_count_105", 0, 32'(cv0), 32'h00105);
        chk("load_count_ovf", 0, 32'(ov0), 32'h0);

        // Multi-channel capture: ch0@10, ch2@25, ch1+ch3@40.
        mode = 2'b00; cycle();
        mode = 2'b11; arm = 1'b1; cycle(); arm = 1'b0;
        for (int i = 0; i < 60 && m_st[0] != 2; i++) begin
            trig = (m_cnt[0] == 10) ? 4'h1 : (m_cnt[0] == 25) ? 4'h4 : (m_cnt[0] == 40) ? 4'hA : 4'h0;
            cycle();
        end
        trig = 4'h0;
        chk("multi_data", 0, 32'(cd0[79:60] == 20'd40 && cd0[59:40] == 20'd25 &&
                               cd0[39:20] == 20'd40 && cd0[19:0] == 20'd10), 32'h1);
        chk("multi_valid", 0, 32'(vl0), 32'hF);
        chk("multi_complete", 0, 32'(cp0), 32'h1);
        ack = 1'b1; cycle(); ack = 1'b0;
        chk("ack_idle", 0, 32'(cp0), 32'h0);
        chk("ack_data_kept", 0, 32'(cd0[19:0]), 32'd10);

        // Narrow counters: timeout on terminal count, wrap vs saturate.
        mode = 2'b00; ack = 1'b1; cycle(); ack = 1'b0;
        mode = 2'b11; arm = 1'b1; cycle(); arm = 1'b0;
        for (int i = 0; i < 30 && m_cnt[1] != 15; i++) begin
            trig = (m_cnt[1] == 3) ? 4'h1 : 4'h0;
            cycle();
        end
        trig = 4'h0; cycle();
        chk("wrap_timeout", 1, 32'(to1), 32'h1);
        chk("wrap_overflow", 1, 32'(ov1), 32'h1);
        chk("wrap_count", 1, 32'(cv1), 32'h0);
        chk("wrap_valid", 1, 32'(vl1), 32'h1);
        chk("sat_count", 2, 32'(cv2), 32'hF);
        chk("sat_overflow", 2, 32'(ov2), 32'h1);
        cycle();
        chk("sat_hold", 2, 32'(cv2), 32'hF);
        mode = 2'b00; cycle();
        chk("sat_clear_cnt", 2, 32'(cv2), 32'h0);
        chk("sat_clear_ovf", 2, 32'(ov2), 32'h0);

        // Level high at arm is not an edge; only the first real edge is captured.
        do_reset();
        trig = 4'h2; cycle();
        mode = 2'b11; arm = 1'b1; cycle(); arm = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("level_no_cap", 0, 32'(vl0), 32'h0);
        trig = 4'h0; cycle();
        e1 = m_cnt[0];
        trig = 4'h2; cycle();
        chk("edge_cap_valid", 0, 32'(vl0), 32'h2);
        chk("edge_cap_data", 0, 32'(cd0[39:20]), e1);
        trig = 4'h0; cycle(); trig = 4'h2; cycle(); cycle();
        chk("second_edge_ignored", 0, 32'(cd0[39:20]), e1);

        // Reset while armed with two channels captured.
        do_reset();
        mode = 2'b11; arm = 1'b1; cycle(); arm = 1'b0;
        trig = 4'h5; cycle(); trig = 4'h0; cycle();
        chk("pre_reset_valid", 0, 32'(vl0), 32'h5);
        do_reset();
        chk("reset_valid", 0, 32'(vl0), 32'h0);
        chk("reset_armed", 0, 32'(ar0), 32'h0);
        trig = 4'h5; cycle(); trig = 4'h0; cycle();
        chk("no_cap_unarmed", 0, 32'(vl0), 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            mode       = ($urandom_range(0, 9) < 6) ? 2'b11 : 2'($urandom_range(0, 3));
            load_value = 20'($urandom);
            arm        = ($urandom_range(0, 7) == 0);
            ack        = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 2) == 0) trig = 4'($urandom);
            cycle();
        end
        arm = 1'b0; ack = 1'b0; trig = 4'h0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
